pc_gen: RTL

Parametrised program-counter generator for the RISC-V core fetch stage. It replaces the single-write PC register with several prioritised redirect channels, a valid/ready fetch handshake with sequential +4 advance, and halt control. Illegal targets no longer leave the PC silently unchanged. A misaligned target, an out-of-range target, or a sequential overrun of instruction memory raises a sticky fault and vectors the PC to a trap address. It sits between the branch/jump/trap resolution logic and the instruction memory port.

---
 rtl/pc_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: prioritised redirects, sequential +4 advance on
// fetch handshake, halt control and a sticky fault that vectors to TRAP_VEC.
module pc_gen #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int unsigned     IMEM_BYTES = 4096,
    parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
    parameter int unsigned     NUM_REDIR  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      fetch_valid,
    input  logic                      fetch_ready,
    output logic [XLEN-1:0]           pc_addr,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_addr,
    input  logic                      halt_req,
    input  logic                      fault_clr,
    output logic                      fault,
    output logic [1:0]                fault_cause,
    output logic [XLEN-1:0]           fault_addr
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0] CAUSE_RANGE   = 2'd2;
    localparam logic [1:0] CAUSE_OVERRUN = 2'd3;

    // One extra bit so the upper bound cannot wrap at the top of the address space.
    localparam logic [XLEN:0] MEM_LO = {1'b0, BOOT_ADDR};
    localparam logic [XLEN:0] MEM_HI = MEM_LO + (XLEN+1)'(IMEM_BYTES);

    function automatic logic [1:0] target_cause(input logic [XLEN-1:0] a);
        if (a[1:0] != 2'b00) begin
            return CAUSE_MISALIGN;
        end
        if (({1'b0, a} < MEM_LO) || ({1'b0, a} >= MEM_HI)) begin
            return CAUSE_RANGE;
        end
        return CAUSE_NONE;
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [XLEN-1:0] faddr_q, faddr_d;

    logic            sel_hit;
    logic [XLEN-1:0] sel_addr;
    logic [1:0]      sel_cause;
    logic [XLEN:0]   seq_next;
    logic            take_fault;
    logic [1:0]      new_cause;
    logic [XLEN-1:0] bad_addr;

    // Scan from the top so the lowest-index asserted channel is the one kept.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                sel_hit  = 1'b1;
                sel_addr = redir_addr[i*XLEN +: XLEN];
            end
        end
    end

    assign sel_cause = target_cause(sel_addr);
    assign seq_next  = {1'b0, pc_q} + (XLEN+1)'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        faddr_d    = faddr_q;
        take_fault = 1'b0;
        new_cause  = CAUSE_NONE;
        bad_addr   = '0;

        case (state_q)
            ST_BOOT: begin
                state_d = halt_req ? ST_HALT : ST_RUN;
            end
            ST_RUN: begin
                if (sel_hit) begin
                    if (sel_cause != CAUSE_NONE) begin
                        take_fault = 1'b1;
                        new_cause  = sel_cause;
                        bad_addr   = sel_addr;
                    end else begin
                        pc_d = sel_addr;
                    end
                end else if (fetch_ready) begin
                    if (seq_next < MEM_HI) begin
                        pc_d = seq_next[XLEN-1:0];
                    end else begin
                        take_fault = 1'b1;
                        new_cause  = CAUSE_OVERRUN;
                        bad_addr   = seq_next[XLEN-1:0];
                    end
                end
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (sel_hit) begin
                    if (sel_cause != CAUSE_NONE) begin
                        take_fault = 1'b1;
                        new_cause  = sel_cause;
                        bad_addr   = sel_addr;
                    end else begin
                        pc_d = sel_addr;
                    end
                end
                if (!halt_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = halt_req ? ST_HALT : ST_RUN;
                    fault_d = 1'b0;
                    cause_d = CAUSE_NONE;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // A fault overrides any halt/run decision made above.
        if (take_fault) begin
            state_d = ST_FAULT;
            pc_d    = TRAP_VEC;
            fault_d = 1'b1;
            cause_d = new_cause;
            faddr_d = bad_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= BOOT_ADDR;
            fault_q <= 1'b0;
            cause_q <= CAUSE_NONE;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            faddr_q <= faddr_d;
        end
    end

    assign fetch_valid = (state_q == ST_RUN);
    assign pc_addr     = pc_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_addr  = faddr_q;

endmodule
